// File: rtl/coef_loader.sv
// Coefficient loader: holds an 8-word shadow register file written by the host
// and streams it into a filter's coefficient port.
// The stream is one write strobe per word, separated by idle gaps.
// When the stream completes, the filter's run level is raised.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | nothing loaded or filter stopped; all outputs low
// ST_WRITE | one-cycle coefficient write of shadow[idx]
// ST_GAP   | enabel low for GAP_CYC cycles after each write (incl. the last)
// ST_RUN   | sequence complete; start held high until stop or a new load
module coef_loader #(
  parameter int NUM_COEF = 8,
  parameter int GAP_CYC  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_wr,
  input  logic [2:0]  host_addr,
  input  logic [31:0] host_data,
  input  logic        load_req,
  input  logic        stop,
  output logic        enabel,
  output logic [2:0]  address,
  output logic [31:0] data,
  output logic        start,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_COEF - 1);
  // The gap down-counter is loaded with GAP_CYC-1 and exits at terminal count 0.
  localparam logic [3:0] GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

  logic [31:0] shadow [8];

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [3:0]  gap_cnt, gap_nxt;

  logic        enabel_nxt;
  logic [2:0]  address_nxt;
  logic [31:0] data_nxt;
  logic        start_nxt;
  logic        busy_nxt;
  logic        done_nxt;

  logic        wr_go;
  logic [2:0]  wr_idx;
  logic        run_go;

  // Shadow register file: host writes land at the edge in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 32'h0;
      end
    end else if (host_wr) begin
      shadow[host_addr] <= host_data;
    end
  end

  // State, index, gap timer and all outputs are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= 3'd0;
      gap_cnt <= 4'd0;
      enabel  <= 1'b0;
      address <= 3'd0;
      data    <= 32'h0;
      start   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      gap_cnt <= gap_nxt;
      enabel  <= enabel_nxt;
      address <= address_nxt;
      data    <= data_nxt;
      start   <= start_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state and next-output decode; the word is captured from the shadow
  // before any same-edge host write, so a colliding write applies next time.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    gap_nxt     = gap_cnt;
    enabel_nxt  = 1'b0;
    address_nxt = address;
    data_nxt    = data;
    start_nxt   = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    wr_go       = 1'b0;
    wr_idx      = 3'd0;
    run_go      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (load_req) begin
          wr_go  = 1'b1;
          wr_idx = 3'd0;
        end
      end

      ST_WRITE: begin
        if (GAP_CYC > 0) begin
          state_nxt = ST_GAP;
          gap_nxt   = GAP_LOAD;
          busy_nxt  = 1'b1;
        end else if (idx == LAST_IDX) begin
          run_go = 1'b1;
        end else begin
          wr_go  = 1'b1;
          wr_idx = idx + 3'd1;
        end
      end

      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          if (idx == LAST_IDX) begin
            run_go = 1'b1;
          end else begin
            wr_go  = 1'b1;
            wr_idx = idx + 3'd1;
          end
        end else begin
          gap_nxt  = gap_cnt - 4'd1;
          busy_nxt = 1'b1;
        end
      end

      ST_RUN: begin
        // A new load takes priority over stop when both arrive together.
        if (load_req) begin
          wr_go  = 1'b1;
          wr_idx = 3'd0;
        end else if (stop) begin
          state_nxt   = ST_IDLE;
          address_nxt = 3'd0;
          data_nxt    = 32'h0;
        end else begin
          start_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        idx_nxt     = 3'd0;
        address_nxt = 3'd0;
        data_nxt    = 32'h0;
      end
    endcase

    if (wr_go) begin
      state_nxt   = ST_WRITE;
      idx_nxt     = wr_idx;
      enabel_nxt  = 1'b1;
      address_nxt = wr_idx;
      data_nxt    = shadow[wr_idx];
      busy_nxt    = 1'b1;
    end

    if (run_go) begin
      state_nxt = ST_RUN;
      start_nxt = 1'b1;
      done_nxt  = 1'b1;
    end
  end

endmodule

// File: tb/tb_coef_loader.sv
// Directed bench for coef_loader: default build (8 words, 2-cycle gaps) plus
// a back-to-back build (3 words, no gaps).
module tb_coef_loader;

  logic        clk;
  logic        reset;

  logic        host_wr;
  logic [2:0]  host_addr;
  logic [31:0] host_data;
  logic        load_req;
  logic        stop;
  logic        enabel;
  logic [2:0]  address;
  logic [31:0] data;
  logic        start;
  logic        busy;
  logic        done;

  logic        g_host_wr;
  logic [2:0]  g_host_addr;
  logic [31:0] g_host_data;
  logic        g_load_req;
  logic        g_stop;
  logic        g_enabel;
  logic [2:0]  g_address;
  logic [31:0] g_data;
  logic        g_start;
  logic        g_busy;
  logic        g_done;

  int          n_chk;
  int          n_pass;
  logic [31:0] exp_d [8];

  coef_loader #(.NUM_COEF(8), .GAP_CYC(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_data (host_data),
    .load_req  (load_req),
    .stop      (stop),
    .enabel    (enabel),
    .address   (address),
    .data      (data),
    .start     (start),
    .busy      (busy),
    .done      (done)
  );

  coef_loader #(.NUM_COEF(3), .GAP_CYC(0)) u_dut_g0 (
    .clk       (clk),
    .reset     (reset),
    .host_wr   (g_host_wr),
    .host_addr (g_host_addr),
    .host_data (g_host_data),
    .load_req  (g_load_req),
    .stop      (g_stop),
    .enabel    (g_enabel),
    .address   (g_address),
    .data      (g_data),
    .start     (g_start),
    .busy      (g_busy),
    .done      (g_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " enabel"},  {31'h0, enabel}, 32'h0);
    check({tag, " address"}, {29'h0, address}, 32'h0);
    check({tag, " data"},    data, 32'h0);
    check({tag, " start"},   {31'h0, start}, 32'h0);
    check({tag, " busy"},    {31'h0, busy}, 32'h0);
    check({tag, " done"},    {31'h0, done}, 32'h0);
  endtask

  // mode 0: plain load; 1: load_req+stop injected in WRITE/GAP;
  // 2: host write of shadow[2] on the edge that enters WRITE idx=2;
  // 3: load_req and stop together to launch the sequence (from RUN).
  task automatic run_seq(input int mode);
    int k;
    logic wr;
    load_req = 1'b1;
    stop     = (mode == 3);
    cyc();
    load_req = 1'b0;
    stop     = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      k  = (t - 1) / 3;
      wr = ((t - 1) % 3) == 0;
      check($sformatf("m%0d t%0d enabel", mode, t),  {31'h0, enabel}, {31'h0, wr});
      check($sformatf("m%0d t%0d address", mode, t), {29'h0, address}, 32'(k));
      check($sformatf("m%0d t%0d data", mode, t),    data, exp_d[k]);
      check($sformatf("m%0d t%0d busy", mode, t),    {31'h0, busy}, 32'h1);
      check($sformatf("m%0d t%0d start", mode, t),   {31'h0, start}, 32'h0);
      check($sformatf("m%0d t%0d done", mode, t),    {31'h0, done}, 32'h0);
      if (mode == 1 && (t == 2 || t == 7 || t == 24)) begin
        load_req = 1'b1;
        stop     = 1'b1;
      end
      if (mode == 2 && t == 6) begin
        host_wr   = 1'b1;
        host_addr = 3'd2;
        host_data = 32'h4000_0000;
      end
      cyc();
      load_req = 1'b0;
      stop     = 1'b0;
      host_wr  = 1'b0;
    end
    check($sformatf("m%0d run done", mode),   {31'h0, done}, 32'h1);
    check($sformatf("m%0d run start", mode),  {31'h0, start}, 32'h1);
    check($sformatf("m%0d run busy", mode),   {31'h0, busy}, 32'h0);
    check($sformatf("m%0d run enabel", mode), {31'h0, enabel}, 32'h0);
    cyc();
    check($sformatf("m%0d run+1 done", mode),   {31'h0, done}, 32'h0);
    check($sformatf("m%0d run+1 start", mode),  {31'h0, start}, 32'h1);
    check($sformatf("m%0d run+1 enabel", mode), {31'h0, enabel}, 32'h0);
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    reset       = 1'b1;
    host_wr     = 1'b0;
    host_addr   = 3'd0;
    host_data   = 32'h0;
    load_req    = 1'b0;
    stop        = 1'b0;
    g_host_wr   = 1'b0;
    g_host_addr = 3'd0;
    g_host_data = 32'h0;
    g_load_req  = 1'b0;
    g_stop      = 1'b0;

    #3;
    check_all_zero("reset");
    cyc();
    cyc();
    #2 reset = 1'b0;
    cyc();
    check_all_zero("post-reset idle");

    // stop while idle does nothing
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    check_all_zero("idle stop");

    // load shadow with 0x3F800000 + k
    for (int i = 0; i < 8; i++) begin
      host_wr   = 1'b1;
      host_addr = 3'(i);
      host_data = 32'h3F80_0000 + 32'(i);
      exp_d[i]  = 32'h3F80_0000 + 32'(i);
      cyc();
    end
    host_wr = 1'b0;
    cyc();
    check("idle no enabel", {31'h0, enabel}, 32'h0);

    run_seq(0);

    // stop in RUN drops start and returns to idle
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_all_zero("run stop");
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("after stop %0d enabel", i), {31'h0, enabel}, 32'h0);
    end

    run_seq(1);
    run_seq(3);
    run_seq(2);
    exp_d[2] = 32'h4000_0000;
    run_seq(0);

    // reset after the 4th write aborts at once and clears the shadow
    load_req = 1'b1;
    cyc();
    load_req = 1'b0;
    for (int t = 1; t < 10; t++) cyc();
    check("pre-abort enabel", {31'h0, enabel}, 32'h1);
    check("pre-abort address", {29'h0, address}, 32'h3);
    cyc();
    #2 reset = 1'b1;
    #1;
    check_all_zero("async reset");
    cyc();
    cyc();
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("post-abort %0d enabel", i), {31'h0, enabel}, 32'h0);
      check($sformatf("post-abort %0d busy", i), {31'h0, busy}, 32'h0);
    end
    for (int i = 0; i < 8; i++) exp_d[i] = 32'h0;
    run_seq(0);

    // back-to-back build: 3 words, no gaps
    for (int i = 0; i < 3; i++) begin
      g_host_wr   = 1'b1;
      g_host_addr = 3'(i);
      g_host_data = 32'hA000_0010 + 32'(i);
      cyc();
    end
    g_host_wr  = 1'b0;
    g_load_req = 1'b1;
    cyc();
    g_load_req = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      check($sformatf("g0 t%0d enabel", t),  {31'h0, g_enabel}, 32'h1);
      check($sformatf("g0 t%0d address", t), {29'h0, g_address}, 32'(t - 1));
      check($sformatf("g0 t%0d data", t),    g_data, 32'hA000_0010 + 32'(t - 1));
      check($sformatf("g0 t%0d start", t),   {31'h0, g_start}, 32'h0);
      check($sformatf("g0 t%0d done", t),    {31'h0, g_done}, 32'h0);
      cyc();
    end
    check("g0 run enabel", {31'h0, g_enabel}, 32'h0);
    check("g0 run start",  {31'h0, g_start}, 32'h1);
    check("g0 run done",   {31'h0, g_done}, 32'h1);
    check("g0 run busy",   {31'h0, g_busy}, 32'h0);
    cyc();
    check("g0 run+1 done",  {31'h0, g_done}, 32'h0);
    check("g0 run+1 start", {31'h0, g_start}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
